// File: rtl/debug_cmd_sync_mc_pkg.sv
// Shared types and default sizing for the debug command synchronizer.
package debug_cmd_sync_mc_pkg;

    localparam int DEF_SR_W        = 38;
    localparam int DEF_IR_W        = 2;
    localparam int DEF_NCH         = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } cmd_state_e;

    function automatic logic [15:0] count_inc(input logic [15:0] value);
        return value + 16'd1;
    endfunction

endpackage

// File: rtl/debug_cmd_sync_mc_if.sv
// JTAG-side strobes/data plus the per-channel command handshake.
interface debug_cmd_sync_mc_if
    import debug_cmd_sync_mc_pkg::*;
#(
    parameter int SR_W = DEF_SR_W,
    parameter int IR_W = DEF_IR_W,
    parameter int NCH  = DEF_NCH
);
    logic [IR_W-1:0] ir_in;
    logic [SR_W-1:0] sr;
    logic            vs_uir;
    logic            vs_udr;
    logic [NCH-1:0]  ch_busy;
    logic [SR_W-1:0] jdo;
    logic [NCH-1:0]  take_action;
    logic [NCH-1:0]  take_no_action;

    modport master (
        output ir_in, sr, vs_uir, vs_udr, ch_busy,
        input  jdo, take_action, take_no_action
    );

    modport slave (
        input  ir_in, sr, vs_uir, vs_udr, ch_busy,
        output jdo, take_action, take_no_action
    );
endinterface

// File: rtl/debug_cmd_sync_mc_strobe_sync.sv
// Multi-flop synchronizer for an asynchronous strobe with a registered rise detector.
module debug_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_in,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign sync_d[gi] = strobe_in;
        end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    always_comb begin
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/debug_cmd_sync_mc.sv
// Moves virtual-JTAG commands into the clk domain and dispatches one-hot
// action / no-action pulses to per-channel consumers.
module debug_cmd_sync_mc
    import debug_cmd_sync_mc_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int NCH         = DEF_NCH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ACT_BIT     = SR_W - 1
) (
    input  logic                clk,
    input  logic                reset_n,
    debug_cmd_sync_mc_if.slave  bus,
    input  logic                err_clr,
    output logic                busy,
    output logic                err_illegal,
    output logic                err_overrun,
    output logic [15:0]         cmd_count
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;

    logic            uir_rise;
    logic            udr_rise;

    logic [1:0]      state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] cmd_ch_q, cmd_ch_d;
    logic [SR_W-1:0] jdo_q, jdo_d;
    logic [NCH-1:0]  act_q, act_d;
    logic [NCH-1:0]  noact_q, noact_d;
    logic            illegal_q, illegal_d;
    logic            overrun_q, overrun_d;
    logic [15:0]     cmd_count_q, cmd_count_d;

    logic [NCH-1:0]  ch_sel;
    logic            ch_legal;
    logic            ch_blocked;
    logic            illegal_set;
    logic            overrun_set;

    debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe_in (bus.vs_uir),
        .rise      (uir_rise)
    );

    debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe_in (bus.vs_udr),
        .rise      (udr_rise)
    );

    // One-hot decode of the latched channel; an index >= NCH decodes to all zeros.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
        assign ch_sel[gi] = (cmd_ch_q == IR_W'(gi));
    end

    assign ch_legal   = |ch_sel;
    assign ch_blocked = |(ch_sel & bus.ch_busy);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cmd_ch_d    = cmd_ch_q;
        jdo_d       = jdo_q;
        act_d       = '0;
        noact_d     = '0;
        cmd_count_d = cmd_count_q;
        illegal_set = 1'b0;
        overrun_set = 1'b0;

        if (uir_rise) begin
            ir_d = bus.ir_in;
        end

        case (state_q)
            S_IDLE: begin
                if (udr_rise) begin
                    jdo_d    = bus.sr;
                    cmd_ch_d = ir_q;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                // A new update-DR while a command is pending is dropped, not queued.
                overrun_set = udr_rise;
                if (!ch_legal) begin
                    illegal_set = 1'b1;
                    state_d     = S_IDLE;
                end else if (ch_blocked) begin
                    state_d = S_WAIT;
                end else begin
                    if (jdo_q[ACT_BIT]) begin
                        act_d = ch_sel;
                    end else begin
                        noact_d = ch_sel;
                    end
                    cmd_count_d = count_inc(cmd_count_q);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        illegal_d = illegal_set | (illegal_q & ~err_clr);
        overrun_d = overrun_set | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            cmd_ch_q    <= '0;
            jdo_q       <= '0;
            act_q       <= '0;
            noact_q     <= '0;
            illegal_q   <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cmd_ch_q    <= cmd_ch_d;
            jdo_q       <= jdo_d;
            act_q       <= act_d;
            noact_q     <= noact_d;
            illegal_q   <= illegal_d;
            overrun_q   <= overrun_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    assign bus.jdo            = jdo_q;
    assign bus.take_action    = act_q;
    assign bus.take_no_action = noact_q;
    assign busy               = (state_q != S_IDLE);
    assign err_illegal        = illegal_q;
    assign err_overrun        = overrun_q;
    assign cmd_count          = cmd_count_q;

endmodule
